// File: rtl/csr_pkg.sv
// Shared definitions for the CSR row datapath: sequencer state encoding and
// default widths shared with the row-pointer fetch unit and the MAC lane.
package csr_pkg;

  localparam int CSR_LEN_W = 5;
  localparam int CSR_ROW_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/csr_row_sequencer_if.sv
// Row-length input stream and element-strobe output stream of the sequencer.
interface csr_row_sequencer_if #(
  parameter int LEN_W = 5,
  parameter int ROW_W = 5
);
  logic             len_valid;
  logic             len_ready;
  logic [LEN_W-1:0] len_data;
  logic             elem_valid;
  logic             elem_ready;
  logic [LEN_W-1:0] elem_idx;
  logic [ROW_W-1:0] row_idx;
  logic             elem_last;

  modport slave (
    input  len_valid, len_data, elem_ready,
    output len_ready, elem_valid, elem_idx, row_idx, elem_last
  );

  modport master (
    output len_valid, len_data, elem_ready,
    input  len_ready, elem_valid, elem_idx, row_idx, elem_last
  );
endinterface

// File: rtl/csr_row_sequencer.sv
// Walks the rows of a CSR job: one row length per row, then one element strobe
// per non-zero under back-pressure. All outputs are decoded from registers.
module csr_row_sequencer
  import csr_pkg::*;
#(
  parameter int LEN_W = CSR_LEN_W,
  parameter int ROW_W = CSR_ROW_W,
  parameter int TOT_W = LEN_W + ROW_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [ROW_W-1:0] num_rows,
  csr_row_sequencer_if.slave bus,
  output logic             row_empty,
  output logic             busy,
  output logic             done,
  output logic [TOT_W-1:0] total
);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] num_rows_q, num_rows_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] elem_idx_q, elem_idx_d;
  logic [ROW_W-1:0] row_idx_q, row_idx_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic             row_empty_q, row_empty_d;

  logic [ROW_W-1:0] cur_row;
  logic             last_row;
  logic             elem_last_w;

  // An empty row keeps row_idx on the consumed row for its pulse cycle; the
  // increment is carried in row_empty_q and folded in on the following cycle.
  assign cur_row     = row_idx_q + ROW_W'(row_empty_q);
  assign last_row    = (cur_row == num_rows_q - ROW_W'(1));
  assign elem_last_w = (state_q == ST_RUN) && (elem_idx_q == len_q - LEN_W'(1));

  always_comb begin
    state_d     = state_q;
    num_rows_d  = num_rows_q;
    len_d       = len_q;
    elem_idx_d  = elem_idx_q;
    row_idx_d   = row_idx_q;
    total_d     = total_q;
    row_empty_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          num_rows_d = num_rows;
          row_idx_d  = '0;
          total_d    = '0;
          elem_idx_d = '0;
          state_d    = (num_rows == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        row_idx_d = cur_row;
        if (abort) begin
          row_idx_d = row_idx_q;
          state_d   = ST_IDLE;
        end else if (bus.len_valid) begin
          if (bus.len_data == '0) begin
            row_empty_d = 1'b1;
            state_d     = last_row ? ST_DONE : ST_FETCH;
          end else begin
            len_d      = bus.len_data;
            elem_idx_d = '0;
            state_d    = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bus.elem_ready) begin
          total_d = total_q + TOT_W'(1);
          if (elem_last_w) begin
            elem_idx_d = '0;
            row_idx_d  = row_idx_q + ROW_W'(1);
            state_d    = (row_idx_q == num_rows_q - ROW_W'(1)) ? ST_DONE : ST_FETCH;
          end else begin
            elem_idx_d = elem_idx_q + LEN_W'(1);
          end
        end
      end
      ST_DONE: begin
        row_idx_d = cur_row;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      num_rows_q  <= '0;
      len_q       <= '0;
      elem_idx_q  <= '0;
      row_idx_q   <= '0;
      total_q     <= '0;
      row_empty_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_rows_q  <= num_rows_d;
      len_q       <= len_d;
      elem_idx_q  <= elem_idx_d;
      row_idx_q   <= row_idx_d;
      total_q     <= total_d;
      row_empty_q <= row_empty_d;
    end
  end

  assign bus.len_ready  = (state_q == ST_FETCH);
  assign bus.elem_valid = (state_q == ST_RUN);
  assign bus.elem_idx   = elem_idx_q;
  assign bus.row_idx    = row_idx_q;
  assign bus.elem_last  = elem_last_w;
  assign row_empty      = row_empty_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign total          = total_q;

endmodule
